// File: rtl/rtsnoc_rx_fifo.sv
// Receive-side flit buffer between an RTSNoC router local port and the Wishbone NoC slave.
// Drains router flits into a small show-ahead FIFO and flags the empty->non-empty transition.
module rtsnoc_rx_fifo #(
  parameter int BUS_WIDTH  = 38,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [BUS_WIDTH-1:0]  rtr_dout_i,
  input  logic                  rtr_nd_i,
  output logic                  rtr_rd_o,
  output logic [BUS_WIDTH-1:0]  fifo_dout_o,
  output logic                  fifo_nd_o,
  input  logic                  fifo_rd_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o,
  output logic                  int_o,
  output logic                  dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // Handshakes: the router holds rtr_nd_i and a stable rtr_dout_i until it
  // sees the one-cycle rtr_rd_o pulse; the slave raises fifo_rd_i (level) and
  // only its rising edge pops, so a held request consumes exactly one flit.
  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [DEPTH_LOG2-1:0]  wp_q, wp_d;
  logic [DEPTH_LOG2-1:0]  rp_q, rp_d;
  logic [DEPTH_LOG2:0]    cnt_q, cnt_d;
  logic                   rd_q, rd_d;
  logic                   rtr_rd_q, rtr_rd_d;
  logic                   int_q, int_d;
  logic [BUS_WIDTH-1:0]   mem_q [DEPTH];

  logic full;
  logic push;
  logic pop;

  always_comb begin
    state_d  = state_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    cnt_d    = cnt_q;
    rd_d     = fifo_rd_i;
    rtr_rd_d = 1'b0;
    int_d    = 1'b0;
    push     = 1'b0;

    full = (cnt_q == DEPTH_CNT);
    pop  = fifo_rd_i && !rd_q && (cnt_q != '0);

    case (state_q)
      IDLE: begin
        if (rtr_nd_i && !full) begin
          push    = 1'b1;
          state_d = SETTLE;
        end
      end
      // One dead cycle so the router can drop nd before we look again.
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) begin
      wp_d     = wp_q + 1'b1;
      rtr_rd_d = 1'b1;
      int_d    = (cnt_q == '0);
    end
    if (pop) begin
      rp_d = rp_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      rtr_rd_q <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      rtr_rd_q <= rtr_rd_d;
      int_q    <= int_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wp_q] <= rtr_dout_i;
    end
  end

  assign rtr_rd_o    = rtr_rd_q;
  assign fifo_dout_o = mem_q[rp_q];
  assign fifo_nd_o   = (cnt_q != '0);
  assign level_o     = cnt_q;
  assign full_o      = full;
  assign int_o       = int_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rtsnoc_rx_fifo.sv
// Directed bench for rtsnoc_rx_fifo: a router model feeds flits, a scoreboard
// queue holds accepted flits in order and is compared against the head on each pop.
module tb_rtsnoc_rx_fifo;

  localparam int BW = 38;
  localparam int DL = 3;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [BW-1:0] rtr_dout  = '0;
  logic          rtr_nd    = 1'b0;
  logic          rtr_rd;
  logic [BW-1:0] fifo_dout;
  logic          fifo_nd;
  logic          fifo_rd   = 1'b0;
  logic [DL:0]   level;
  logic          full;
  logic          irq;
  logic          dbg_state;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] router_q[$];

  int chk_cnt    = 0;
  int pass_cnt   = 0;
  int rd_pulses  = 0;
  int int_pulses = 0;

  rtsnoc_rx_fifo #(.BUS_WIDTH(BW), .DEPTH_LOG2(DL)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .rtr_dout_i  (rtr_dout),
    .rtr_nd_i    (rtr_nd),
    .rtr_rd_o    (rtr_rd),
    .fifo_dout_o (fifo_dout),
    .fifo_nd_o   (fifo_nd),
    .fifo_rd_i   (fifo_rd),
    .level_o     (level),
    .full_o      (full),
    .int_o       (irq),
    .dbg_state_o (dbg_state)
  );

  // Clock
  initial begin
    forever #5 clk = ~clk;
  end

  // Router model: offers the front of router_q, retires it on seeing rd.
  initial begin
    forever begin
      @(negedge clk);
      if (rtr_rd) rd_pulses++;
      if (irq) int_pulses++;
      if (rtr_rd && rtr_nd && router_q.size() > 0) exp_q.push_back(router_q.pop_front());
      rtr_nd   = (router_q.size() > 0);
      rtr_dout = (router_q.size() > 0) ? router_q[0] : '0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (router_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("router_drain", 64'(router_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_head(input string tag);
    logic [BW-1:0] e;
    check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    check(tag, 64'(fifo_dout), 64'(e));
    fifo_rd = 1'b1;
    @(negedge clk);
    fifo_rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int p0;
    int i0;
    int n;
    logic [BW-1:0] e;

    // Reset state
    #12;
    check("rst_rd", 64'(rtr_rd), 64'd0);
    check("rst_nd", 64'(fifo_nd), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_int", 64'(irq), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single flit
    p0 = rd_pulses;
    i0 = int_pulses;
    router_q.push_back(38'h2A_0000_1234);
    wait_drain();
    check("t1_rd_pulses", 64'(rd_pulses - p0), 64'd1);
    check("t1_int_pulses", 64'(int_pulses - i0), 64'd1);
    check("t1_level", 64'(level), 64'd1);
    check("t1_nd", 64'(fifo_nd), 64'd1);
    check("t1_dout", 64'(fifo_dout), 64'h2A_0000_1234);
    pop_head("t1_head");
    check("t1_empty_nd", 64'(fifo_nd), 64'd0);
    check("t1_empty_level", 64'(level), 64'd0);

    // Fill to full
    p0 = rd_pulses;
    for (int i = 1; i <= 9; i++) router_q.push_back(BW'(i));
    n = 0;
    while (level != 4'd8 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check("t2_rd_pulses", 64'(rd_pulses - p0), 64'd8);
    check("t2_full", 64'(full), 64'd1);
    check("t2_level", 64'(level), 64'd8);
    check("t2_left_in_router", 64'(router_q.size()), 64'd1);
    check("t2_router_nd", 64'(rtr_nd), 64'd1);
    pop_head("t2_head1");
    check("t2_refill_level", 64'(level), 64'd8);
    check("t2_refill_router", 64'(router_q.size()), 64'd0);
    for (int i = 2; i <= 9; i++) pop_head("t2_drain");
    check("t2_drained_level", 64'(level), 64'd0);

    // Held read
    for (int i = 0; i < 3; i++) router_q.push_back(BW'('h300 + i));
    wait_drain();
    check("t3_level3", 64'(level), 64'd3);
    e = exp_q.pop_front();
    check("t3_first", 64'(fifo_dout), 64'(e));
    fifo_rd = 1'b1;
    repeat (4) @(negedge clk);
    fifo_rd = 1'b0;
    @(negedge clk);
    check("t3_level2", 64'(level), 64'd2);
    check("t3_second", 64'(fifo_dout), 64'(BW'('h301)));
    pop_head("t3_drain");
    pop_head("t3_drain");

    // Simultaneous push and pop across pointer wrap
    for (int i = 0; i < 4; i++) router_q.push_back(BW'('h400 + i));
    wait_drain();
    check("t4_level4", 64'(level), 64'd4);
    for (int i = 0; i < 20; i++) begin
      router_q.push_back(BW'('h500 + i));
      n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (!rtr_nd && n < 10);
      check("t4_router_nd", 64'(rtr_nd), 64'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check("t4_head", 64'(fifo_dout), 64'(e));
      fifo_rd = 1'b1;
      @(negedge clk);
      fifo_rd = 1'b0;
      #1;
      check("t4_level_hold", 64'(level), 64'd4);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) pop_head("t4_drain");
    check("t4_drained_level", 64'(level), 64'd0);

    // Empty pop
    fifo_rd = 1'b1;
    @(negedge clk);
    fifo_rd = 1'b0;
    @(negedge clk);
    check("t5_level", 64'(level), 64'd0);
    check("t5_nd", 64'(fifo_nd), 64'd0);
    router_q.push_back(BW'('h5EE));
    wait_drain();
    check("t5_level1", 64'(level), 64'd1);
    pop_head("t5_head");

    // Async reset mid-SETTLE at level 5
    for (int i = 0; i < 4; i++) router_q.push_back(BW'('h600 + i));
    wait_drain();
    check("t6_level4", 64'(level), 64'd4);
    router_q.push_back(BW'('h6AA));
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!rtr_rd && n < 20);
    check("t6_rd", 64'(rtr_rd), 64'd1);
    check("t6_settle", 64'(dbg_state), 64'd1);
    check("t6_level5", 64'(level), 64'd5);
    rst_n = 1'b0;
    router_q.delete();
    exp_q.delete();
    #1;
    check("t6_rst_rd", 64'(rtr_rd), 64'd0);
    check("t6_rst_nd", 64'(fifo_nd), 64'd0);
    check("t6_rst_level", 64'(level), 64'd0);
    check("t6_rst_full", 64'(full), 64'd0);
    check("t6_rst_int", 64'(irq), 64'd0);
    check("t6_rst_state", 64'(dbg_state), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_post_level", 64'(level), 64'd0);
    check("t6_post_nd", 64'(fifo_nd), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
